// File: rtl/cfg_sequencer.sv
// Configure-then-execute sequencer for the switch/PE mesh: streams config packets in under load, drains, then runs.
// Optional macro CFG_SEQ_CHECKSUM_EN adds o_cfg_checksum (XOR of accepted packets this pass).
module cfg_sequencer #(
    parameter int NUM_PKTS     = 16,
    parameter int DRAIN_CYCLES = 8,
    parameter int RUN_CYCLES   = 256,
    localparam int PCW  = $clog2(NUM_PKTS + 1),
    localparam int MAXC = (DRAIN_CYCLES > RUN_CYCLES) ? DRAIN_CYCLES : RUN_CYCLES,
    localparam int CW   = $clog2(MAXC + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_cfg_valid,
    output logic            o_cfg_ready,
    input  logic [47:0]     i_cfg_data,
    output logic            o_load,
    output logic [47:0]     o_cfg_out,
    output logic            o_cfg_out_valid,
    output logic            o_run_en,
    output logic            o_busy,
    output logic            o_done,
    output logic [PCW-1:0]  o_pkt_count
`ifdef CFG_SEQ_CHECKSUM_EN
    ,
    output logic [47:0]     o_cfg_checksum
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [PCW-1:0]  r_pkt_count, w_pkt_count_next;
    logic [47:0]     r_cfg_out, w_cfg_out_next;
    logic            r_cfg_out_valid, w_cfg_out_valid_next;
    logic            r_done, w_done_next;
    logic            r_load, r_run_en, r_cfg_ready, r_busy;
`ifdef CFG_SEQ_CHECKSUM_EN
    logic [47:0]     r_checksum, w_checksum_next;
`endif

    always_comb begin
        w_state_next         = r_state;
        w_cnt_next           = r_cnt;
        w_pkt_count_next     = r_pkt_count;
        w_cfg_out_next       = 48'h0;
        w_cfg_out_valid_next = 1'b0;
        w_done_next          = r_done;
`ifdef CFG_SEQ_CHECKSUM_EN
        w_checksum_next      = r_checksum;
`endif
        case (r_state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_next     = LOAD;
                    w_cnt_next       = '0;
                    w_pkt_count_next = '0;
                    w_done_next      = 1'b0;
`ifdef CFG_SEQ_CHECKSUM_EN
                    w_checksum_next  = 48'h0;
`endif
                end
            end
            LOAD: begin
                // cfg_ready is registered high throughout LOAD, so valid alone completes a handshake
                if (i_cfg_valid) begin
                    w_cfg_out_next       = i_cfg_data;
                    w_cfg_out_valid_next = 1'b1;
                    w_pkt_count_next     = r_pkt_count + PCW'(1);
`ifdef CFG_SEQ_CHECKSUM_EN
                    w_checksum_next      = r_checksum ^ i_cfg_data;
`endif
                    if (r_pkt_count == PCW'(NUM_PKTS - 1)) begin
                        w_state_next = DRAIN;
                        w_cnt_next   = '0;
                    end
                end
            end
            DRAIN: begin
                w_cnt_next = r_cnt + CW'(1);
                if (r_cnt == CW'(DRAIN_CYCLES - 1)) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end
            end
            RUN: begin
                w_cnt_next = r_cnt + CW'(1);
                if (r_cnt == CW'(RUN_CYCLES - 1)) begin
                    w_state_next = DONE;
                    w_cnt_next   = '0;
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_done_next  = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Abort suppresses any handshake in the same cycle; counters stay for debug
        if (i_abort && r_state != IDLE) begin
            w_state_next         = IDLE;
            w_cnt_next           = '0;
            w_pkt_count_next     = r_pkt_count;
            w_cfg_out_next       = 48'h0;
            w_cfg_out_valid_next = 1'b0;
            w_done_next          = r_done;
`ifdef CFG_SEQ_CHECKSUM_EN
            w_checksum_next      = r_checksum;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_pkt_count     <= '0;
            r_cfg_out       <= 48'h0;
            r_cfg_out_valid <= 1'b0;
            r_done          <= 1'b0;
            r_load          <= 1'b0;
            r_run_en        <= 1'b0;
            r_cfg_ready     <= 1'b0;
            r_busy          <= 1'b0;
`ifdef CFG_SEQ_CHECKSUM_EN
            r_checksum      <= 48'h0;
`endif
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_pkt_count     <= w_pkt_count_next;
            r_cfg_out       <= w_cfg_out_next;
            r_cfg_out_valid <= w_cfg_out_valid_next;
            r_done          <= w_done_next;
            r_load          <= (w_state_next == LOAD) || (w_state_next == DRAIN);
            r_run_en        <= (w_state_next == RUN);
            r_cfg_ready     <= (w_state_next == LOAD);
            r_busy          <= (w_state_next != IDLE);
`ifdef CFG_SEQ_CHECKSUM_EN
            r_checksum      <= w_checksum_next;
`endif
        end
    end

    assign o_cfg_ready     = r_cfg_ready;
    assign o_load          = r_load;
    assign o_cfg_out       = r_cfg_out;
    assign o_cfg_out_valid = r_cfg_out_valid;
    assign o_run_en        = r_run_en;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pkt_count     = r_pkt_count;
`ifdef CFG_SEQ_CHECKSUM_EN
    assign o_cfg_checksum  = r_checksum;
`endif

endmodule

// File: tb/tb_cfg_sequencer.sv
// Self-checking bench for cfg_sequencer: timeline-based reference model, directed table and random passes.
module tb_cfg_sequencer;

    localparam int N = 4;
    localparam int D = 8;
    localparam int R = 16;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start, i_abort, i_cfg_valid;
    logic [47:0] i_cfg_data;
    logic        o_cfg_ready, o_load, o_cfg_out_valid, o_run_en, o_busy, o_done;
    logic [47:0] o_cfg_out;
    logic [2:0]  o_pkt_count;
`ifdef CFG_SEQ_CHECKSUM_EN
    logic [47:0] o_cfg_checksum;
`endif

    always #5 clk = ~clk;

    cfg_sequencer #(.NUM_PKTS(N), .DRAIN_CYCLES(D), .RUN_CYCLES(R)) dut (
        .i_clk(clk),
        .i_rst_n(i_rst_n),
        .i_start(i_start),
        .i_abort(i_abort),
        .i_cfg_valid(i_cfg_valid),
        .o_cfg_ready(o_cfg_ready),
        .i_cfg_data(i_cfg_data),
        .o_load(o_load),
        .o_cfg_out(o_cfg_out),
        .o_cfg_out_valid(o_cfg_out_valid),
        .o_run_en(o_run_en),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_pkt_count(o_pkt_count)
`ifdef CFG_SEQ_CHECKSUM_EN
        ,
        .o_cfg_checksum(o_cfg_checksum)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: mode 0 idle, 1 accepting, 2 timed (drain/run/done derived from elapsed cycles)
    int          m_mode, m_t, m_ps, m_cnt;
    logic [47:0] m_out, m_csum;
    bit          m_ov, m_done;

    logic [56:0] hist [0:63];
    int          hidx = -1;

    typedef struct {
        int          cyc;
        logic [5:0]  flags;   // {load, run_en, cfg_ready, cfg_out_valid, busy, done}
        int          pkts;
        logic [47:0] out;
    } vec_t;

    vec_t        tbl [11];
    logic [47:0] pk [4];

    function automatic logic [56:0] act_bundle();
        return {o_load, o_run_en, o_cfg_ready, o_cfg_out_valid, o_busy, o_done, o_pkt_count, o_cfg_out};
    endfunction

    function automatic logic [56:0] exp_bundle();
        int  el;
        bit  ld, rn;
        el = m_t - m_ps;
        ld = (m_mode == 1) || (m_mode == 2 && el < D);
        rn = (m_mode == 2) && (el >= D) && (el < D + R);
        return {ld, rn, (m_mode == 1), m_ov, (m_mode != 0), m_done, 3'(m_cnt), m_out};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_out = 48'h0; m_ov = 1'b0; m_done = 1'b0; m_csum = 48'h0;
    endtask

    task automatic model_edge(input bit st, input bit ab, input bit v, input logic [47:0] d);
        int el;
        el = m_t - m_ps;
        m_t++;
        m_out = 48'h0;
        m_ov  = 1'b0;
        if (ab && m_mode != 0) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (st && !ab) begin
                    m_mode = 1; m_cnt = 0; m_done = 1'b0; m_csum = 48'h0;
                end
                1: if (v) begin
                    m_out = d; m_ov = 1'b1; m_cnt++; m_csum ^= d;
                    if (m_cnt == N) begin
                        m_mode = 2; m_ps = m_t;
                    end
                end
                default: if (el == D + R) begin
                    m_mode = 0; m_done = 1'b1;
                end
            endcase
        end
    endtask

    task automatic check_all();
        logic [56:0] a, e;
        a = act_bundle();
        e = exp_bundle();
        n_vec++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL cycle t=%0d: got %h want %h", m_t, a, e);
        end
`ifdef CFG_SEQ_CHECKSUM_EN
        n_vec++;
        if (o_cfg_checksum !== m_csum) begin
            n_fail++;
            $display("FAIL checksum t=%0d: got %h want %h", m_t, o_cfg_checksum, m_csum);
        end
`endif
        if (hidx >= 0 && hidx < 64) hist[hidx] = a;
        if (hidx >= 0) hidx++;
    endtask

    task automatic step(input bit st, input bit ab, input bit v, input logic [47:0] d);
        i_start = st; i_abort = ab; i_cfg_valid = v; i_cfg_data = d;
        @(posedge clk);
        model_edge(st, ab, v, d);
        #1;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 48'h0);
    endtask

    task automatic check_eq(input string name, input logic [47:0] got, input logic [47:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic [47:0] rd;
        bit          vpat [7];

        pk[0] = {8'h80, 2'd1, 2'd1, 4'd3, 32'h0000_0005};
        pk[1] = {8'h41, 2'd2, 2'd0, 4'd1, 32'h0000_000A};
        pk[2] = {8'h22, 2'd0, 2'd3, 4'd7, 32'h0000_000B};
        pk[3] = {8'h13, 2'd3, 2'd2, 4'd9, 32'h0000_000C};
        tbl[0]  = '{1,  6'b101010, 0, 48'h0};
        tbl[1]  = '{2,  6'b101110, 1, pk[0]};
        tbl[2]  = '{3,  6'b101110, 2, pk[1]};
        tbl[3]  = '{4,  6'b101110, 3, pk[2]};
        tbl[4]  = '{5,  6'b100110, 4, pk[3]};
        tbl[5]  = '{6,  6'b100010, 4, 48'h0};
        tbl[6]  = '{12, 6'b100010, 4, 48'h0};
        tbl[7]  = '{13, 6'b010010, 4, 48'h0};
        tbl[8]  = '{28, 6'b010010, 4, 48'h0};
        tbl[9]  = '{29, 6'b000010, 4, 48'h0};
        tbl[10] = '{30, 6'b000001, 4, 48'h0};

        m_t = 0; m_ps = 0;
        model_reset();
        i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_cfg_valid = 1'b0; i_cfg_data = 48'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", {9'h0, act_bundle()}, 48'h0);
        i_rst_n = 1'b1;
        idle_cycles(2);

        // Undisturbed pass with valid held high; outputs captured per cycle for the table
        hidx = 1;
        step(1'b1, 1'b0, 1'b0, 48'h0);
        for (int k = 1; k <= 30; k++) step(1'b0, 1'b0, 1'b1, (k <= 4) ? pk[k-1] : 48'hDEAD);
        hidx = -1;
        for (int i = 0; i < 11; i++) begin
            n_vec++;
            if (hist[tbl[i].cyc] !== {tbl[i].flags, 3'(tbl[i].pkts), tbl[i].out}) begin
                n_fail++;
                $display("FAIL table cyc%0d: got %h want %h", tbl[i].cyc, hist[tbl[i].cyc],
                         {tbl[i].flags, 3'(tbl[i].pkts), tbl[i].out});
            end
        end

        // Bursty valid during LOAD
        vpat = '{1, 0, 0, 1, 1, 0, 1};
        step(1'b1, 1'b0, 1'b0, 48'h0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, vpat[k], pk[k % 4] ^ 48'h5A);
        idle_cycles(28);

        // Abort in the third RUN cycle, then restart
        step(1'b1, 1'b0, 1'b0, 48'h0);
        for (int k = 1; k <= 14; k++) step(1'b0, 1'b0, 1'b1, pk[(k - 1) % 4]);
        step(1'b0, 1'b1, 1'b0, 48'h0);
        check_eq("abort_run_done", {46'h0, o_run_en, o_done}, 48'h0);
        step(1'b1, 1'b0, 1'b0, 48'h0);
        check_eq("restart_pkt_count", {45'h0, o_pkt_count}, 48'h0);
        for (int k = 0; k < 31; k++) step(1'b0, 1'b0, 1'b1, pk[k % 4]);

        // start pulses inside LOAD and RUN must not disturb the pass
        step(1'b1, 1'b0, 1'b0, 48'h0);
        for (int k = 0; k < 31; k++)
            step((k == 1) || (k == 15) || (k == 16), 1'b0, 1'b1, pk[k % 4]);

        // Abort together with start in IDLE
        step(1'b1, 1'b1, 1'b0, 48'h0);
        check_eq("abort_beats_start", {47'h0, o_busy}, 48'h0);

        // Checksum pass with one-hot packets
        step(1'b1, 1'b0, 1'b0, 48'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 48'h1 << k);
`ifdef CFG_SEQ_CHECKSUM_EN
        check_eq("checksum_after_4", o_cfg_checksum, 48'hF);
`endif
        idle_cycles(30);
`ifdef CFG_SEQ_CHECKSUM_EN
        check_eq("checksum_held", o_cfg_checksum, 48'hF);
`endif
        check_eq("done_sticky", {47'h0, o_done}, 48'h1);

        // Asynchronous reset in the middle of RUN
        step(1'b1, 1'b0, 1'b0, 48'h0);
        for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 1'b1, pk[k % 4]);
        #3 i_rst_n = 1'b0;
        #1;
        check_eq("async_reset", {9'h0, act_bundle()}, 48'h0);
        model_reset();
        @(posedge clk);
        #1 i_rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 48'h0);
        check_eq("post_reset_busy", {47'h0, o_busy}, 48'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rd = {16'($urandom), $urandom};
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 2) != 0), rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
